dmux4way16_router: RTL and testbench
====================================

// Module: dmux4way16_router
// PURPOSE
//   Registered 1-to-4 demultiplexer: the routing counterpart of the 16-bit 4-way mux.
//   - Accepts one WIDTH-bit word per handshake on a single input stream.
//   - Steers the word to one of four output channels (a,b,c,d) selected by a 2-bit sel.
//   - Each channel holds the word in a one-entry output register until its consumer takes it.
//   - Sits between the datapath and the register-file / memory write ports.
// PARAMETERS
//   WIDTH   16  data width of the input and of each output channel
//   CNT_W   8   width of the per-channel transfer counters (DMUX_COUNT_EN builds only)
// PORTS
//   clk         in   1      single clock; all state updates on rising edge
//   reset       in   1      synchronous, active-high reset
//   in_data     in   WIDTH  word to route
//   in_sel      in   2      destination: 00=a, 01=b, 10=c, 11=d
//   in_valid    in   1      in_data/in_sel valid this cycle
//   in_ready    out  1      router accepts the input word this cycle
//   a_data      out  WIDTH  channel a word (b_data, c_data, d_data identical)
//   a_valid     out  1      channel a holds a word (b_valid, c_valid, d_valid identical)
//   a_ready     in   1      channel a consumer takes the word (b_ready, c_ready, d_ready identical)
//   cnt_a..d    out  CNT_W  transfers delivered per channel (DMUX_COUNT_EN builds only)
// BEHAVIOUR
//   - Reset: all x_valid=0, all x_data=0, cnt_x=0; in_ready follows its combinational rule.
//   - Per channel x: full_x == x_valid. Output handshake fires when x_valid & x_ready.
//   - in_ready = ~full[in_sel] | ready[in_sel]; combinational, depends only on the selected channel.
//   - Accept = in_valid & in_ready. On accept:
//       - x_data <= in_data for x = in_sel.
//       - x_valid <= 1 on the next edge.
//       - Latency in->out is exactly 1 cycle.
//   - Channel drains with no new write: x_valid <= 0; x_data holds its last value.
//   - Simultaneous drain and refill of the same channel: the new word replaces the old one and
//     x_valid stays 1. One word per cycle sustained, no bubble.
//   - Only one channel is written per cycle. The other channels drain independently in the same cycle.
//   - Blocked write (selected channel full, not draining): in_ready=0 and nothing changes.
//     Upstream must hold in_data and in_sel stable until accept.
//   - x_data and x_valid are stable while x_valid & ~x_ready.
//   - Reset asserted mid-transfer: pending words are discarded and valids clear on that edge.
//     An accept in the reset cycle is ignored.
//   - No state machine beyond the four full flags.
//   - Widths are exact: data is passed through with no extension or truncation.
// CONFIGURATION
//   DMUX_COUNT_EN defined:
//     - cnt_a..cnt_d ports exist.
//     - cnt_x increments by 1 on each x_valid & x_ready.
//     - Counters wrap modulo 2**CNT_W (255 -> 0) with no flag.
//     - Reset clears all counters.
//   DMUX_COUNT_EN undefined:
//     - Counter ports and logic are absent.
//     - Routing behaviour is identical.
// STRUCTURE
//   - Package dmux_pkg:
//     - localparam SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11
//     - localparam NUM_CH=4
//     - typedef logic [1:0] dmux_sel_t
//   - Sub-module dmux_chan_reg: one-entry register slice per channel, instantiated 4x.
//     - Ports: clk, reset, wr_en, wr_data, valid, ready, data, plus optional counter.
//   - Top level: sel decode to a one-hot wr_en, plus the in_ready mux over the four
//     (full, ready) pairs.
// TESTING
//   1. Reset for 2 cycles -> all valid=0, all data=0, in_ready=1, cnt_x=0.
//   2. in_sel=10, in_data=16'hBEEF, 1-cycle pulse, c_ready=0 -> next cycle c_data=BEEF and
//      c_valid=1; a, b, d valid=0.
//   3. c still full, c_ready=0, second word 16'h1234 to sel=10 -> in_ready=0 and c_data stays
//      BEEF. Raise c_ready -> 1234 accepted that cycle and appears next cycle with no gap.
//   4. Stream 8 words to sel=00,01,10,11,00,... with all ready=1 -> in_ready=1 every cycle.
//      Each word appears on its channel exactly 1 cycle later; 2 per channel, in order.
//   5. d full with d_ready=0 while writing sel=01 word 16'h00AA -> accepted. b_valid=1 next
//      cycle and d is unchanged.
//   6. Reset asserted while a_valid=1 and b_valid=1 -> both 0 after the edge.
//      DMUX_COUNT_EN build: 256 drains on a -> cnt_a wraps to 0.

Source files
------------

// File: rtl/dmux4way16_router_pkg.sv
// Shared channel encoding for the 1-to-4 registered demultiplexer.
// Optional per-channel transfer counters are enabled by defining DMUX_COUNT_EN.
package dmux_pkg;
    localparam logic [1:0] SEL_A  = 2'b00;
    localparam logic [1:0] SEL_B  = 2'b01;
    localparam logic [1:0] SEL_C  = 2'b10;
    localparam logic [1:0] SEL_D  = 2'b11;
    localparam int         NUM_CH = 4;

    typedef logic [1:0] dmux_sel_t;
endpackage

// File: rtl/dmux4way16_router_chan_reg.sv
// One-entry output register slice for a single router channel.
// With DMUX_COUNT_EN defined it also counts delivered words (wrapping).
module dmux_chan_reg #(
    parameter int WIDTH = 16
`ifdef DMUX_COUNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data
`ifdef DMUX_COUNT_EN
    , output logic [CNT_W-1:0] cnt
`endif
);
    // A write wins over a drain, so a same-cycle drain and refill keeps valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            data  <= wr_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

`ifdef DMUX_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (valid && ready) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif
endmodule

// File: rtl/dmux4way16_router.sv
// Registered 1-to-4 demultiplexer routing one input stream to channels a..d.
// Define DMUX_COUNT_EN to add per-channel delivered-word counters cnt_a..cnt_d.
module dmux4way16_router
    import dmux_pkg::*;
#(
    parameter int WIDTH = 16
`ifdef DMUX_COUNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] c_data,
    output logic             c_valid,
    input  logic             c_ready,
    output logic [WIDTH-1:0] d_data,
    output logic             d_valid,
    input  logic             d_ready
`ifdef DMUX_COUNT_EN
    , output logic [CNT_W-1:0] cnt_a
    , output logic [CNT_W-1:0] cnt_b
    , output logic [CNT_W-1:0] cnt_c
    , output logic [CNT_W-1:0] cnt_d
`endif
);
    dmux_sel_t         sel;
    logic              accept;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] rdy;
    logic [NUM_CH-1:0] wr_en;
    logic [WIDTH-1:0]  ch_data [NUM_CH];
`ifdef DMUX_COUNT_EN
    logic [CNT_W-1:0]  ch_cnt  [NUM_CH];
`endif

    assign sel    = in_sel;
    assign rdy    = {d_ready, c_ready, b_ready, a_ready};
    // Only the selected channel gates the input; other channels never stall it.
    assign in_ready = ~full[sel] | rdy[sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        wr_en = '0;
        case (sel)
            SEL_A:   wr_en[0] = accept;
            SEL_B:   wr_en[1] = accept;
            SEL_C:   wr_en[2] = accept;
            SEL_D:   wr_en[3] = accept;
            default: wr_en    = '0;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        dmux_chan_reg #(
            .WIDTH (WIDTH)
`ifdef DMUX_COUNT_EN
            , .CNT_W (CNT_W)
`endif
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[g]),
            .wr_data (in_data),
            .valid   (full[g]),
            .ready   (rdy[g]),
            .data    (ch_data[g])
`ifdef DMUX_COUNT_EN
            , .cnt   (ch_cnt[g])
`endif
        );
    end

    assign a_valid = full[0];
    assign b_valid = full[1];
    assign c_valid = full[2];
    assign d_valid = full[3];
    assign a_data  = ch_data[0];
    assign b_data  = ch_data[1];
    assign c_data  = ch_data[2];
    assign d_data  = ch_data[3];
`ifdef DMUX_COUNT_EN
    assign cnt_a   = ch_cnt[0];
    assign cnt_b   = ch_cnt[1];
    assign cnt_c   = ch_cnt[2];
    assign cnt_d   = ch_cnt[3];
`endif
endmodule

// File: tb/tb_dmux4way16_router.sv
// Scoreboard bench for dmux4way16_router; counter checks compile in with DMUX_COUNT_EN.
module tb_dmux4way16_router;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_data, b_data, c_data, d_data;
    logic        a_valid, b_valid, c_valid, d_valid;
    logic        a_ready = 1'b0, b_ready = 1'b0, c_ready = 1'b0, d_ready = 1'b0;
`ifdef DMUX_COUNT_EN
    logic [7:0]  cnt_a, cnt_b, cnt_c, cnt_d;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmux4way16_router dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .c_data   (c_data),
        .c_valid  (c_valid),
        .c_ready  (c_ready),
        .d_data   (d_data),
        .d_valid  (d_valid),
        .d_ready  (d_ready)
`ifdef DMUX_COUNT_EN
        , .cnt_a  (cnt_a)
        , .cnt_b  (cnt_b)
        , .cnt_c  (cnt_c)
        , .cnt_d  (cnt_d)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: each queue holds the word expected in that channel's register.
    logic [15:0] sb [4][$];
    logic [15:0] last_data [4];
    logic [7:0]  mcnt [4];
    logic        mon_en = 1'b0;
    logic [15:0] o_data [4];
    logic [3:0]  o_valid, o_ready;
    logic [7:0]  o_cnt [4];

    always_comb begin
        o_data[0] = a_data; o_data[1] = b_data; o_data[2] = c_data; o_data[3] = d_data;
        o_valid = {d_valid, c_valid, b_valid, a_valid};
        o_ready = {d_ready, c_ready, b_ready, a_ready};
`ifdef DMUX_COUNT_EN
        o_cnt[0] = cnt_a; o_cnt[1] = cnt_b; o_cnt[2] = cnt_c; o_cnt[3] = cnt_d;
`else
        o_cnt[0] = '0; o_cnt[1] = '0; o_cnt[2] = '0; o_cnt[3] = '0;
`endif
    end

    always @(negedge clk) begin
        logic exp_rdy;
        logic [15:0] w;
        exp_rdy = 1'b0;
        if (mon_en) begin
            for (int ch = 0; ch < 4; ch++) begin
                chk($sformatf("sb_valid%0d", ch), {31'd0, o_valid[ch]},
                    {31'd0, sb[ch].size() != 0});
                if (sb[ch].size() != 0)
                    chk($sformatf("sb_data%0d", ch), {16'd0, o_data[ch]}, {16'd0, sb[ch][0]});
                else
                    chk($sformatf("sb_hold%0d", ch), {16'd0, o_data[ch]}, {16'd0, last_data[ch]});
`ifdef DMUX_COUNT_EN
                chk($sformatf("sb_cnt%0d", ch), {24'd0, o_cnt[ch]}, {24'd0, mcnt[ch]});
`endif
            end
            exp_rdy = (sb[in_sel].size() == 0) || o_ready[in_sel];
            chk("sb_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        end
        // Advance the model to the state expected after the coming rising edge.
        if (reset) begin
            for (int ch = 0; ch < 4; ch++) begin
                sb[ch].delete();
                last_data[ch] = '0;
                mcnt[ch] = '0;
            end
            mon_en = 1'b1;
        end else if (mon_en) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (sb[ch].size() != 0 && o_ready[ch]) begin
                    w = sb[ch].pop_front();
                    last_data[ch] = w;
                    mcnt[ch] = mcnt[ch] + 8'd1;
                end
            end
            if (in_valid && exp_rdy) sb[in_sel].push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [15:0] d);
        in_sel = s; in_data = d; in_valid = 1'b1;
    endtask

    initial begin
        // 1. reset
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_d_data", {16'd0, d_data}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DMUX_COUNT_EN
        chk("rst_cnt_b", {24'd0, cnt_b}, 32'd0);
`endif

        // 2. single word to c
        send(2'b10, 16'hBEEF);
        step();
        in_valid = 1'b0;
        chk("t2_c_valid", {31'd0, c_valid}, 32'd1);
        chk("t2_c_data", {16'd0, c_data}, 32'h0000BEEF);
        chk("t2_others", {29'd0, a_valid, b_valid, d_valid}, 32'd0);

        // 3. blocked write then release with no gap
        send(2'b10, 16'h1234);
        #1;
        chk("t3_blocked", {31'd0, in_ready}, 32'd0);
        step();
        chk("t3_c_hold", {16'd0, c_data}, 32'h0000BEEF);
        c_ready = 1'b1;
        #1;
        chk("t3_release", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("t3_c_new", {16'd0, c_data}, 32'h00001234);
        chk("t3_c_valid", {31'd0, c_valid}, 32'd1);
        step();
        chk("t3_c_drained", {31'd0, c_valid}, 32'd0);

        // 4. round-robin stream with all consumers ready
        {a_ready, b_ready, c_ready, d_ready} = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            send(i[1:0], (i == 3) ? 16'hFFFF : (i == 5) ? 16'h0000 : 16'h1000 + i[15:0]);
            #1;
            chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        chk("t4_d_last", {16'd0, d_data}, 32'h00001007);
        step();

        // 5. write b while d is stalled full
        {a_ready, b_ready, c_ready, d_ready} = 4'b0000;
        send(2'b11, 16'h0DDD);
        step();
        send(2'b01, 16'h00AA);
        #1;
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("t5_b_data", {16'd0, b_data}, 32'h000000AA);
        chk("t5_d_kept", {15'd0, d_valid, d_data}, 32'h00010DDD);

        // 6. reset while a and b hold words; accept in the reset cycle is ignored
        send(2'b00, 16'h0A0A);
        step();
        chk("t6_ab_full", {30'd0, a_valid, b_valid}, 32'd3);
        send(2'b11, 16'hFFFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("t6_ab_clear", {30'd0, a_valid, b_valid}, 32'd0);
        chk("t6_d_clear", {15'd0, d_valid, d_data}, 32'd0);

        // Counter wrap: 256 deliveries on channel a
        a_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(2'b00, i[15:0]);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_a_valid", {31'd0, a_valid}, 32'd0);
`ifdef DMUX_COUNT_EN
        chk("wrap_cnt_a", {24'd0, cnt_a}, 32'd0);
`endif
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench time limit");
    end
endmodule
